intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller directly upstream of the pipeline; drives the pipeline's 8-bit intr input.
- Synchronizes 8 external interrupt lines and latches each as an edge or level event into a pending register.
- Applies a software-written mask and presents one prioritized request to the pipeline.
- Holds that request stable through a request/acknowledge/end-of-interrupt handshake.

Parameters:
- NSRC, 8, number of interrupt sources; must equal the pipeline's intr width.
- IDW, 3, width of the source index, equal to clog2(NSRC).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; all state is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- src_in  in  NSRC  raw asynchronous interrupt lines, active-high.
- cfg_we  in  1  write strobe for the mask and mode registers.
- cfg_mask  in  NSRC  mask value; 1 enables the source.
- cfg_edge  in  NSRC  mode value; 1 selects rising-edge, 0 selects level.
- intr  out  NSRC  one-hot vector of the currently requested source, to the pipeline.
- irq_id  out  IDW  index of the requested source.
- irq_valid  out  1  a request is presented.
- irq_ack  in  1  pipeline has taken the interrupt (one cycle).
- irq_eoi  in  1  handler finished (one cycle).
- pending  out  NSRC  raw pending register, for software read.

Behaviour:
- Reset (rst=0, asynchronous):
  - mask=0, mode=0, pending=0.
  - All synchronizer flops=0, FSM=IDLE.
  - intr=0, irq_id=0, irq_valid=0.
- Synchronizer: src_s is src_in delayed by SYNC_STAGES flops. The edge detector keeps src_s_d, the previous value of src_s.
- Config: when cfg_we=1, mask and mode load at the clock edge. A new mask takes effect on the following cycle's selection.
- Pending set:
  - Edge source: set when src_s & ~src_s_d.
  - Level source: set when src_s.
  - Set has priority over clear in the same cycle.
- Pending clear:
  - Edge source: clears on irq_ack for the acked index.
  - Level source: clears on irq_ack and re-sets the next cycle if the line is still high.
- Selection: eligible = pending & mask. The lowest index has highest priority; sel_id is the lowest set bit of eligible.
- FSM, 3 states:
  - IDLE:
    - If eligible != 0, latch sel_id into cur_id and go to REQ.
    - Outputs: irq_valid=0, intr=0.
  - REQ:
    - irq_valid=1, irq_id=cur_id, intr=1<<cur_id.
    - cur_id is frozen: a higher-priority arrival does not preempt a presented request.
    - irq_ack=1: clear pending[cur_id] and go to SERVICE.
    - If software masks cur_id while in REQ with no ack: return to IDLE, irq_valid drops the next cycle, pending is kept.
  - SERVICE:
    - irq_valid=0, intr=0. New events still accumulate in pending.
    - irq_eoi=1: go to IDLE.
    - Nesting is not supported.
- Latency:
  - src_in rise to pending set: SYNC_STAGES+1 cycles.
  - pending set to irq_valid: 1 cycle (IDLE to REQ).
  - Minimum src_in to irq_valid: SYNC_STAGES+2 cycles.
- Spurious inputs are ignored:
  - irq_ack outside REQ.
  - irq_eoi outside SERVICE.
  - irq_ack and irq_eoi asserted together.
- Reset mid-operation: asynchronous return to the reset values, discarding pending state and any in-service state.
- All outputs are registered; none is combinational from an input.

Decomposition:
- Package intr_pkg:
  - NSRC and IDW constants.
  - FSM state enum: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - Priority-encode function, lowest set bit to index plus found flag.
- Sub-module intr_sync: a SYNC_STAGES-deep, NSRC-wide synchronizer with asynchronous active-low reset, instantiated once.
- Pending logic, selection and the FSM stay in intr_ctrl.

Test Plan:
- Reset, edge accept:
  - Stimulus: hold rst=0 for 20ns, release; cfg_we with mask=8'hFF, edge=8'hFF; pulse src_in[3] for 1 cycle.
  - Required: irq_valid=1, irq_id=3, intr=8'h08 exactly SYNC_STAGES+2 cycles after the pulse.
  - Then: ack clears pending[3]; eoi returns to IDLE with intr=0.
- Priority:
  - Stimulus: src_in[5] and src_in[1] rise in the same cycle.
  - Required: first irq_id=1. After ack and eoi, irq_id=5 on the next cycle after IDLE.
- Masked source:
  - Stimulus: mask=8'hFE, src_in[0] pulses.
  - Required: pending[0]=1, irq_valid stays 0.
  - Then: writing mask=8'hFF produces irq_id=0 within 2 cycles.
- Level re-assert:
  - Stimulus: edge=0, src_in[2] held high through ack and eoi.
  - Required: pending[2] re-sets and a second request with irq_id=2 follows.
  - Then: with src_in[2] low before ack, no second request.
- Stable request:
  - Stimulus: in REQ with irq_id=4, src_in[0] fires.
  - Required: irq_id stays 4 until ack; irq_id=0 is presented after eoi.
- Spurious handshake and async reset:
  - Stimulus: irq_ack in IDLE; irq_eoi in REQ.
  - Required: no state or pending change.
  - Stimulus: rst=0 asserted in SERVICE, mid-cycle.
  - Required: all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared constants, FSM encoding and priority encoder for the interrupt controller.
package intr_pkg;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    typedef struct packed {
        logic           found;
        logic [IDW-1:0] id;
    } prio_t;

    // Lowest set bit wins.
    function automatic prio_t prio_enc(input logic [NSRC-1:0] v);
        prio_t r;
        r.found = 1'b0;
        r.id    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.id    = IDW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_sync.sv
// Multi-stage flop synchronizer for the raw interrupt lines.
module intr_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending capture, masking, priority select and
// request/ack/eoi handshake towards the pipeline.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_in,
    input  logic            cfg_we,
    input  logic [NSRC-1:0] cfg_mask,
    input  logic [NSRC-1:0] cfg_edge,
    output logic [NSRC-1:0] intr,
    output logic [IDW-1:0]  irq_id,
    output logic            irq_valid,
    input  logic            irq_ack,
    input  logic            irq_eoi,
    output logic [NSRC-1:0] pending
);

    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] src_s_d;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] set;
    logic [IDW-1:0]  cur_id;
    logic [IDW-1:0]  cur_id_nx;
    logic            ack_ok;
    logic            eoi_ok;
    prio_t           sel;
    state_t          state;
    state_t          state_nx;

    intr_sync #(
        .W      (NSRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (src_in),
        .q   (src_s)
    );

    assign eligible = pending & mask;
    assign sel      = prio_enc(eligible);
    assign ack_ok   = irq_ack & ~irq_eoi & (state == REQ);
    assign eoi_ok   = irq_eoi & ~irq_ack & (state == SERVICE);
    assign clr      = ack_ok ? (NSRC'(1) << cur_id) : '0;

    // A level line held high reappears one cycle after its ack clear.
    assign set = (mode & src_s & ~src_s_d) | (~mode & src_s & ~clr);

    always_comb begin
        state_nx  = state;
        cur_id_nx = cur_id;
        unique case (state)
            IDLE: begin
                if (sel.found) begin
                    cur_id_nx = sel.id;
                    state_nx  = REQ;
                end
            end
            REQ: begin
                if (ack_ok) begin
                    state_nx = SERVICE;
                end else if (!mask[cur_id]) begin
                    state_nx = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_ok) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_s_d   <= '0;
            mask      <= '0;
            mode      <= '0;
            pending   <= '0;
            state     <= IDLE;
            cur_id    <= '0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            intr      <= '0;
        end else begin
            src_s_d <= src_s;
            pending <= (pending & ~clr) | set;
            state   <= state_nx;
            cur_id  <= cur_id_nx;
            if (cfg_we) begin
                mask <= cfg_mask;
                mode <= cfg_edge;
            end
            // Outputs follow the next state so they come straight from flops.
            irq_valid <= (state_nx == REQ);
            irq_id    <= (state_nx == REQ) ? cur_id_nx : '0;
            intr      <= (state_nx == REQ) ? (NSRC'(1) << cur_id_nx) : '0;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed plus randomized bench for intr_ctrl against a cycle reference model.
module tb_intr_ctrl;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] src_in = '0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_mask = '0;
    logic [7:0] cfg_edge = '0;
    logic [7:0] intr;
    logic [2:0] irq_id;
    logic       irq_valid;
    logic       irq_ack = 1'b0;
    logic       irq_eoi = 1'b0;
    logic [7:0] pending;

    int checks = 0;
    int failures = 0;

    // Reference model: line history, pending bits, handshake phase.
    bit [7:0] hist [SS+1];
    bit [7:0] m_pend;
    bit [7:0] m_mask;
    bit [7:0] m_edge;
    int       m_st;
    int       m_cur;

    intr_ctrl #(.SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_in    (src_in),
        .cfg_we    (cfg_we),
        .cfg_mask  (cfg_mask),
        .cfg_edge  (cfg_edge),
        .intr      (intr),
        .irq_id    (irq_id),
        .irq_valid (irq_valid),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (hist[i]) hist[i] = '0;
        m_pend = '0;
        m_mask = '0;
        m_edge = '0;
        m_st   = 0;
        m_cur  = 0;
    endtask

    // Apply one clock edge worth of rules to the model using current inputs.
    task automatic model_edge();
        bit [7:0] s, sd, elig, clr, set;
        s    = hist[SS-1];
        sd   = hist[SS];
        elig = m_pend & m_mask;
        clr  = '0;
        if (m_st == 1 && irq_ack && !irq_eoi) clr = 8'(1 << m_cur);
        set = (m_edge & s & ~sd) | (~m_edge & s & ~clr);
        case (m_st)
            0: if (elig != 0) begin
                for (int i = 7; i >= 0; i--) if (elig[i]) m_cur = i;
                m_st = 1;
            end
            1: if (clr != 0) m_st = 2;
               else if (!m_mask[m_cur]) m_st = 0;
            2: if (irq_eoi && !irq_ack) m_st = 0;
            default: m_st = 0;
        endcase
        m_pend = (m_pend & ~clr) | set;
        if (cfg_we) begin
            m_mask = cfg_mask;
            m_edge = cfg_edge;
        end
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = src_in;
    endtask

    task automatic compare();
        chk("valid", irq_valid, (m_st == 1));
        chk("irq_id", irq_id, (m_st == 1) ? m_cur : 0);
        chk("intr", intr, (m_st == 1) ? (1 << m_cur) : 0);
        chk("pending", pending, m_pend);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !irq_valid; i++) tick();
        chk(tag, irq_valid, 1);
    endtask

    task automatic cfg(input logic [7:0] m, input logic [7:0] e);
        cfg_we = 1'b1; cfg_mask = m; cfg_edge = e;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        src_in = v;
        tick();
        src_in = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic eoi();
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    initial begin
        model_reset();
        #20;
        chk("rst_valid", irq_valid, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_intr", intr, 0);
        chk("rst_pending", pending, 0);
        @(negedge clk);
        rst = 1'b1;

        // Edge accept and exact latency
        cfg(8'hFF, 8'hFF);
        pulse(8'h08);
        ticks(2);
        chk("lat_early", irq_valid, 0);
        tick();
        chk("lat_valid", irq_valid, 1);
        chk("lat_id", irq_id, 3);
        chk("lat_intr", intr, 8'h08);
        ack();
        chk("ack_pend3", pending[3], 0);
        eoi();
        chk("eoi_intr", intr, 0);

        // Priority between simultaneous edges
        pulse(8'h22);
        wait_valid("prio_wait1");
        chk("prio_first", irq_id, 1);
        ack();
        eoi();
        chk("prio_idle", irq_valid, 0);
        tick();
        chk("prio_second", irq_id, 5);
        ack();
        eoi();

        // Masked source then unmask
        cfg(8'hFE, 8'hFF);
        pulse(8'h01);
        ticks(5);
        chk("mask_pend0", pending[0], 1);
        chk("mask_novalid", irq_valid, 0);
        cfg(8'hFF, 8'hFF);
        tick();
        chk("unmask_valid", irq_valid, 1);
        chk("unmask_id", irq_id, 0);
        ack();
        eoi();

        // Level source re-assert
        cfg(8'hFF, 8'h00);
        src_in = 8'h04;
        wait_valid("lvl_wait1");
        chk("lvl_id1", irq_id, 2);
        ack();
        eoi();
        wait_valid("lvl_wait2");
        chk("lvl_id2", irq_id, 2);
        src_in = '0;
        ticks(4);
        ack();
        eoi();
        ticks(3);
        chk("lvl_none", irq_valid, 0);
        chk("lvl_pend", pending[2], 0);
        cfg(8'hFF, 8'hFF);

        // Presented request stays stable
        pulse(8'h10);
        wait_valid("stab_wait");
        chk("stab_id", irq_id, 4);
        pulse(8'h01);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stab_hold", irq_id, 4);
        end
        ack();
        eoi();
        tick();
        chk("stab_next", irq_id, 0);
        ack();
        eoi();

        // Spurious handshakes
        ack();
        chk("sp_ack_valid", irq_valid, 0);
        chk("sp_ack_pend", pending, 0);
        pulse(8'h40);
        wait_valid("sp_wait");
        eoi();
        chk("sp_eoi_valid", irq_valid, 1);
        chk("sp_eoi_id", irq_id, 6);
        irq_ack = 1'b1; irq_eoi = 1'b1;
        tick();
        irq_ack = 1'b0; irq_eoi = 1'b0;
        chk("sp_both_valid", irq_valid, 1);
        chk("sp_both_pend", pending[6], 1);
        ack();
        pulse(8'h80);
        ticks(4);
        chk("svc_pend7", pending[7], 1);

        // Asynchronous reset in SERVICE, mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", irq_valid, 0);
        chk("arst_id", irq_id, 0);
        chk("arst_intr", intr, 0);
        chk("arst_pending", pending, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cfg_we   = ($urandom_range(15) == 0);
            cfg_mask = 8'($urandom);
            cfg_edge = 8'($urandom);
            src_in   = 8'($urandom & $urandom & $urandom);
            irq_ack  = ($urandom_range(3) == 0);
            irq_eoi  = ($urandom_range(3) == 0);
            tick();
        end
        cfg_we = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0; src_in = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
